// File: rtl/counter_call_dispatcher_if.sv
// Bundles the dispatcher's ticket/call inputs and its display/service outputs.
// Latency: none, wiring only.
// Backpressure: none; the dispatcher side is the slave modport, the ticket/counter side is master.
// Ports: take_pulse, call_req[4:0] (master -> slave); current_number, wait_count, queue_full,
//   call_valid, counter_call[2:0], number_service, counter_busy[4:0],
//   A_serviceNumber .. E_serviceNumber (slave -> master).
interface counter_call_dispatcher_if #(
  parameter int NUM_W = 6
);
  logic             take_pulse;
  logic [4:0]       call_req;
  logic [NUM_W-1:0] current_number;
  logic [NUM_W-1:0] wait_count;
  logic             queue_full;
  logic             call_valid;
  logic [2:0]       counter_call;
  logic [NUM_W-1:0] number_service;
  logic [4:0]       counter_busy;
  logic [NUM_W-1:0] A_serviceNumber;
  logic [NUM_W-1:0] B_serviceNumber;
  logic [NUM_W-1:0] C_serviceNumber;
  logic [NUM_W-1:0] D_serviceNumber;
  logic [NUM_W-1:0] E_serviceNumber;

  modport master (
    output take_pulse, call_req,
    input  current_number, wait_count, queue_full, call_valid, counter_call,
           number_service, counter_busy, A_serviceNumber, B_serviceNumber,
           C_serviceNumber, D_serviceNumber, E_serviceNumber
  );

  modport slave (
    input  take_pulse, call_req,
    output current_number, wait_count, queue_full, call_valid, counter_call,
           number_service, counter_busy, A_serviceNumber, B_serviceNumber,
           C_serviceNumber, D_serviceNumber, E_serviceNumber
  );
endinterface

// File: rtl/counter_call_dispatcher.sv
// Issues ticket numbers and grants the next waiting ticket to one of five service counters per cycle.
// Latency: call_req latched at edge N, earliest grant registered at edge N+1; takes count from their edge.
// Backpressure: takes dropped while queue_full; busy counters' requests ignored; pending calls wait for tickets.
// Ports: clk, rst (sync, active high); bus = counter_call_dispatcher_if.slave (see interface file).
// Optional: define COUNTER_A_PRIORITY_EN to make counter A win whenever eligible, B..E round-robin.
module counter_call_dispatcher #(
  parameter int NUM_W          = 6,
  parameter int MAX_TICKET     = 63,
  parameter int QUEUE_MAX      = 31,
  parameter int SERVICE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  counter_call_dispatcher_if.slave bus
);
  localparam int TW = $clog2(SERVICE_CYCLES + 1);

  logic [NUM_W-1:0] curNum, waitCnt, nextServe, numService;
  logic [NUM_W-1:0] svcNum [5];
  logic [TW-1:0]    timer [5];
  logic [4:0]       pending, busy, eligible, rrMask, grantOh;
  logic [2:0]       ptr, grantIdx, counterCall, idx;
  logic [3:0]       sumIdx;
  logic             grantVld, callValid, takeOk, queueFull;

  // Ticket numbers run 1..MAX_TICKET; 0 only appears out of reset.
  function automatic logic [NUM_W-1:0] wrapInc(input logic [NUM_W-1:0] v);
    return (v == NUM_W'(MAX_TICKET)) ? NUM_W'(1) : v + NUM_W'(1);
  endfunction

  assign queueFull = (waitCnt == NUM_W'(QUEUE_MAX));
  assign takeOk    = bus.take_pulse && !queueFull;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      busy[i] = (timer[i] != '0);
    end
  end

  assign eligible = pending & ~busy;

  // Round-robin search from ptr+1: scan offsets from farthest to nearest so
  // the nearest eligible counter overwrites and wins.
  always_comb begin
    grantVld = 1'b0;
    grantIdx = '0;
    sumIdx   = '0;
    idx      = '0;
    rrMask   = eligible;
`ifdef COUNTER_A_PRIORITY_EN
    rrMask[0] = 1'b0;
`endif
    for (int k = 5; k >= 1; k--) begin
      sumIdx = {1'b0, ptr} + 4'(k);
      idx    = (sumIdx >= 4'd5) ? 3'(sumIdx - 4'd5) : sumIdx[2:0];
      if (rrMask[idx]) begin
        grantVld = 1'b1;
        grantIdx = idx;
      end
    end
`ifdef COUNTER_A_PRIORITY_EN
    if (eligible[0]) begin
      grantVld = 1'b1;
      grantIdx = 3'd0;
    end
`endif
    // Only tickets already counted before this edge can be served.
    if (waitCnt == '0) begin
      grantVld = 1'b0;
      grantIdx = '0;
    end
  end

  assign grantOh = grantVld ? (5'b00001 << grantIdx) : 5'b00000;

  always_ff @(posedge clk) begin
    if (rst) begin
      curNum      <= '0;
      waitCnt     <= '0;
      nextServe   <= NUM_W'(1);
      numService  <= '0;
      pending     <= '0;
      ptr         <= 3'd4;
      callValid   <= 1'b0;
      counterCall <= '0;
      for (int i = 0; i < 5; i++) begin
        timer[i]  <= '0;
        svcNum[i] <= '0;
      end
    end else begin
      if (takeOk) begin
        curNum <= wrapInc(curNum);
      end
      // A take and a grant on the same edge cancel out.
      case ({takeOk, grantVld})
        2'b10:   waitCnt <= waitCnt + NUM_W'(1);
        2'b01:   waitCnt <= waitCnt - NUM_W'(1);
        default: waitCnt <= waitCnt;
      endcase
      pending <= (pending | (bus.call_req & ~busy)) & ~grantOh;
      for (int i = 0; i < 5; i++) begin
        if (grantOh[i]) begin
          timer[i]  <= TW'(SERVICE_CYCLES);
          svcNum[i] <= nextServe;
        end else if (timer[i] != '0) begin
          timer[i] <= timer[i] - TW'(1);
        end
      end
      callValid   <= grantVld;
      counterCall <= grantVld ? grantIdx + 3'd1 : 3'd0;
      if (grantVld) begin
        numService <= nextServe;
        nextServe  <= wrapInc(nextServe);
`ifdef COUNTER_A_PRIORITY_EN
        if (grantIdx != 3'd0) begin
          ptr <= grantIdx;
        end
`else
        ptr <= grantIdx;
`endif
      end
    end
  end

  assign bus.current_number  = curNum;
  assign bus.wait_count      = waitCnt;
  assign bus.queue_full      = queueFull;
  assign bus.call_valid      = callValid;
  assign bus.counter_call    = counterCall;
  assign bus.number_service  = numService;
  assign bus.counter_busy    = busy;
  assign bus.A_serviceNumber = svcNum[0];
  assign bus.B_serviceNumber = svcNum[1];
  assign bus.C_serviceNumber = svcNum[2];
  assign bus.D_serviceNumber = svcNum[3];
  assign bus.E_serviceNumber = svcNum[4];
endmodule

// File: tb/tb_counter_call_dispatcher.sv
// Directed bench for counter_call_dispatcher with a grant scoreboard.
// Expected grants are queued when calls/takes are driven and popped when call_valid pulses.
module tb_counter_call_dispatcher;
  localparam int NUM_W = 6;

  typedef struct packed {
    logic [2:0]       ctr;
    logic [NUM_W-1:0] num;
  } grantExpT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nCompared   = 0;
  int nMismatched = 0;
  grantExpT expQ[$];
  grantExpT monExp;

  counter_call_dispatcher_if #(.NUM_W(NUM_W)) bus ();

  counter_call_dispatcher #(
    .NUM_W(NUM_W), .MAX_TICKET(63), .QUEUE_MAX(31), .SERVICE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic takeN(input int n);
    bus.take_pulse = 1'b1;
    tick(n);
    bus.take_pulse = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic pushExp(input int c, input int n);
    grantExpT e;
    e.ctr = 3'(c);
    e.num = NUM_W'(n);
    expQ.push_back(e);
  endtask

  task automatic drain(input string tag);
    int cnt = 0;
    while (expQ.size() != 0 && cnt < 40) begin
      tick(1);
      cnt++;
    end
    chk({"drain_", tag}, expQ.size(), 0);
  endtask

  function automatic logic [NUM_W-1:0] svcOf(input logic [2:0] c);
    case (c)
      3'd1:    return bus.A_serviceNumber;
      3'd2:    return bus.B_serviceNumber;
      3'd3:    return bus.C_serviceNumber;
      3'd4:    return bus.D_serviceNumber;
      3'd5:    return bus.E_serviceNumber;
      default: return '0;
    endcase
  endfunction

  // Grant monitor: every call_valid pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (bus.call_valid === 1'b1) begin
      nCompared++;
      assert (expQ.size() != 0) else begin
        nMismatched++;
        $error("FAIL unexpected_grant: observed counter %0d number %0d, expected no grant",
               bus.counter_call, bus.number_service);
      end
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        chk("grant_counter", bus.counter_call, monExp.ctr);
        chk("grant_number", bus.number_service, monExp.num);
        chk("grant_svcnum", svcOf(monExp.ctr), monExp.num);
      end
    end else begin
      chk("idle_counter_call", bus.counter_call, 0);
    end
  end

  initial begin
    int cnt;
    int c;
    bus.take_pulse = 1'b0;
    bus.call_req   = 5'b0;

    // Reset state
    tick(2);
    rst = 1'b0;
    chk("rst_current", bus.current_number, 0);
    chk("rst_wait", bus.wait_count, 0);
    chk("rst_full", bus.queue_full, 0);
    chk("rst_valid", bus.call_valid, 0);
    chk("rst_counter", bus.counter_call, 0);
    chk("rst_nserv", bus.number_service, 0);
    chk("rst_busy", bus.counter_busy, 0);
    chk("rst_svcA", bus.A_serviceNumber, 0);
    chk("rst_svcE", bus.E_serviceNumber, 0);

    // Two takes, then A calls
    takeN(2);
    chk("t2_current", bus.current_number, 2);
    chk("t2_wait", bus.wait_count, 2);
    bus.call_req = 5'b00001;
    pushExp(1, 1);
    tick(1);
    bus.call_req = 5'b0;
    chk("t2_no_early_grant", bus.call_valid, 0);
    tick(1);
    chk("t2_valid", bus.call_valid, 1);
    chk("t2_counter", bus.counter_call, 1);
    chk("t2_nserv", bus.number_service, 1);
    chk("t2_svcA", bus.A_serviceNumber, 1);
    chk("t2_wait_after", bus.wait_count, 1);
    cnt = 0;
    while (bus.counter_busy[0] === 1'b1 && cnt < 20) begin
      cnt++;
      tick(1);
    end
    chk("t2_busy_cycles", cnt, 8);

    // Three takes, all five call: A,B,C served, D and E wait for tickets
    doReset();
    takeN(3);
    chk("t3_wait", bus.wait_count, 3);
    bus.call_req = 5'b11111;
    pushExp(1, 1);
    pushExp(2, 2);
    pushExp(3, 3);
    tick(1);
    bus.call_req = 5'b0;
    drain("t3_abc");
    tick(3);
    chk("t3_wait_empty", bus.wait_count, 0);
    pushExp(4, 4);
    takeN(1);
    chk("t3_wait_take", bus.wait_count, 1);
    drain("t3_d");
    pushExp(5, 5);
    takeN(1);
    drain("t3_e");
    chk("t3_wait_end", bus.wait_count, 0);

    // Queue full
    doReset();
    takeN(31);
    chk("t4_full", bus.queue_full, 1);
    chk("t4_current", bus.current_number, 31);
    chk("t4_wait", bus.wait_count, 31);
    takeN(1);
    chk("t4_current_drop", bus.current_number, 31);
    chk("t4_wait_drop", bus.wait_count, 31);
    chk("t4_full_hold", bus.queue_full, 1);

    // Wrap: issue and serve 63 tickets, then one more
    doReset();
    for (int i = 1; i <= 63; i++) begin
      c = i % 5;
      bus.call_req   = 5'(1 << c);
      bus.take_pulse = 1'b1;
      pushExp(c + 1, i);
      tick(1);
      bus.take_pulse = 1'b0;
      bus.call_req   = 5'b0;
      tick(1);
    end
    chk("t5_current63", bus.current_number, 63);
    chk("t5_wait0", bus.wait_count, 0);
    chk("t5_nserv63", bus.number_service, 63);
    bus.call_req   = 5'b10000;
    bus.take_pulse = 1'b1;
    pushExp(5, 1);
    tick(1);
    bus.take_pulse = 1'b0;
    bus.call_req   = 5'b0;
    chk("t5_current_wrap", bus.current_number, 1);
    drain("t5_wrap");

    // Pending D on empty queue, mid-operation reset clears it
    doReset();
    bus.call_req = 5'b01000;
    tick(1);
    bus.call_req = 5'b0;
    tick(3);
    chk("t6_wait_empty", bus.wait_count, 0);
    doReset();
    takeN(1);
    tick(4);
    chk("t6_wait_kept", bus.wait_count, 1);
    chk("t6_busy", bus.counter_busy, 0);

    // Pointer to A, then A and B together
    bus.call_req = 5'b00001;
    pushExp(1, 1);
    tick(1);
    bus.call_req = 5'b0;
    drain("t6_a");
    cnt = 0;
    while (bus.counter_busy[0] === 1'b1 && cnt < 20) begin
      cnt++;
      tick(1);
    end
    chk("t6_a_idle", bus.counter_busy[0], 0);
    takeN(2);
    chk("t6_wait2", bus.wait_count, 2);
    bus.call_req = 5'b00011;
`ifdef COUNTER_A_PRIORITY_EN
    pushExp(1, 2);
    pushExp(2, 3);
`else
    pushExp(2, 2);
    pushExp(1, 3);
`endif
    tick(1);
    bus.call_req = 5'b0;
    drain("t6_ab");
    chk("t6_wait_end", bus.wait_count, 0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
